// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the 64-bit core's load/store port.
// Doubleword-organised little-endian RAM with a fixed number of wait cycles
// per access, RISC-V B/H/W/D sizes, sign/zero extension on loads, and
// misalignment/range/encoding fault detection.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   readEnable      load request
//   writeEnable     store request
//   addr            byte address
//   writeData       store data, right-aligned
//   funct3          [1:0] size (B/H/W/D), [2] unsigned load
//   readData        extended load result (registered, holds until next load)
//   stall           core must hold its state (combinational)
//   done            one-cycle access-complete pulse
//   fault           completed access was illegal (valid with done)
module dmem_responder #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         readEnable,
  input  logic         writeEnable,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] writeData,
  input  logic [2:0]   funct3,
  output logic [N-1:0] readData,
  output logic         stall,
  output logic         done,
  output logic         fault
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [3:0]     LP_CNT   = 4'(LATENCY - 1);
  localparam logic [N-4:0]   LP_DEPTH = (N-3)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         r_state, w_next;
  logic [N-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_idx;
  logic [2:0]     r_off;
  logic [N-1:0]   r_wdata;
  logic [2:0]     r_funct3;
  logic           r_store;
  logic [3:0]     r_cnt;
  logic [N-1:0]   r_readData;
  logic           r_fault;

  logic           w_req, w_misal, w_range, w_illegal, w_commit;
  logic [N-1:0]   w_old, w_wshift, w_rshift, w_merged, w_load;
  logic [7:0]     w_lanes, w_bmask;
  logic           w_sx;

  assign w_req    = readEnable | writeEnable;
  assign readData = r_readData;
  assign fault    = r_fault;

  // Request legality, evaluated on the live inputs while IDLE.
  always_comb begin
    w_misal = 1'b0;
    case (funct3[1:0])
      2'b00: w_misal = 1'b0;
      2'b01: w_misal = addr[0];
      2'b10: w_misal = |addr[1:0];
      2'b11: w_misal = |addr[2:0];
      default: w_misal = 1'b0;
    endcase
    w_range   = addr[N-1:3] >= LP_DEPTH;
    w_illegal = (readEnable & writeEnable) | w_misal | w_range |
                (readEnable & (funct3 == 3'b111)) | (writeEnable & funct3[2]);
  end

  // Lane steering: data is shifted to/from byte offset r_off; the byte mask
  // selects which lanes of the old doubleword a store replaces.
  always_comb begin
    w_old    = r_mem[r_idx];
    w_lanes  = 8'h01;
    case (r_funct3[1:0])
      2'b00: w_lanes = 8'h01;
      2'b01: w_lanes = 8'h03;
      2'b10: w_lanes = 8'h0F;
      2'b11: w_lanes = 8'hFF;
      default: w_lanes = 8'h01;
    endcase
    w_bmask  = w_lanes << r_off;
    w_wshift = r_wdata << {r_off, 3'b000};
    w_merged = w_old;
    for (int unsigned k = 0; k < 8; k++) begin
      if (w_bmask[k]) w_merged[8*k +: 8] = w_wshift[8*k +: 8];
    end
    w_rshift = w_old >> {r_off, 3'b000};
    w_sx     = ~r_funct3[2];
    w_load   = w_rshift;
    case (r_funct3[1:0])
      2'b00: w_load = {{(N-8){w_sx & w_rshift[7]}},   w_rshift[7:0]};
      2'b01: w_load = {{(N-16){w_sx & w_rshift[15]}}, w_rshift[15:0]};
      2'b10: w_load = {{(N-32){w_sx & w_rshift[31]}}, w_rshift[31:0]};
      default: w_load = w_rshift;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    done     = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          stall  = 1'b1;
          w_next = w_illegal ? RESP : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_readData <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_illegal) begin
              r_fault <= 1'b1;
            end else begin
              r_idx    <= addr[AW+2:3];
              r_off    <= addr[2:0];
              r_wdata  <= writeData;
              r_funct3 <= funct3;
              r_store  <= writeEnable;
              r_cnt    <= LP_CNT;
            end
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_fault <= 1'b0;
            if (!r_store) r_readData <= w_load;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is not reset; a store aborted by reset never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && r_store) r_mem[r_idx] <= w_merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        readEnable, writeEnable;
  logic [63:0] addr, writeData;
  logic [2:0]  funct3;
  logic [63:0] readData;
  logic        stall, done, fault;

  dmem_responder #(.N(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .readEnable(readEnable), .writeEnable(writeEnable),
    .addr(addr), .writeData(writeData), .funct3(funct3),
    .readData(readData), .stall(stall), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic        flt;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_m [0:8*DEPTH-1];
  logic [63:0] last_rd;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_now  = 0;
  int          last_done_cyc;

  always @(posedge clk) cyc_now++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endfunction

  // Reference model: byte-array RAM, expected response computed from the
  // access rules directly.
  function automatic exp_t model(bit re, bit we, logic [63:0] a, logic [63:0] d,
                                 logic [2:0] f3, string nm);
    exp_t        e;
    int unsigned size;
    logic [63:0] v;
    bit          bad;
    size = 1 << f3[1:0];
    bad  = (re && we) || (a % size != 0) || (a / 8 >= DEPTH) ||
           (re && f3 == 3'b111) || (we && f3[2]);
    e.name = nm;
    e.flt  = bad;
    if (!bad && we) begin
      for (int unsigned i = 0; i < size; i++) mem_m[a + i] = d[8*i +: 8];
    end else if (!bad) begin
      v = '0;
      for (int unsigned i = 0; i < size; i++) v[8*i +: 8] = mem_m[a + i];
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | ({64{1'b1}} << (8*size));
      last_rd = v;
    end
    e.rd = last_rd;
    return e;
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no response pending");
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_rd"}, readData, e.rd);
        chk({e.name, "_fault"}, {63'b0, fault}, {63'b0, e.flt});
      end
    end
  end

  // Issue one access (called #1 after a posedge) and wait for its done.
  task automatic access(input bit re, input bit we, input logic [63:0] a,
                        input logic [63:0] d, input logic [2:0] f3,
                        input bit hold, input string nm);
    exp_t e;
    int   lat_exp, n;
    bit   got;
    readEnable  = re;
    writeEnable = we;
    addr        = a;
    writeData   = d;
    funct3      = f3;
    e = model(re, we, a, d, f3, nm);
    sb_q.push_back(e);
    lat_exp = e.flt ? 1 : LAT + 1;
    n   = 0;
    got = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      chk({nm, "_stall_busy"}, {63'b0, stall}, 64'd1);
      n++;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end else begin
      last_done_cyc = cyc_now;
      chk({nm, "_latency"}, 64'(n), 64'(lat_exp));
      chk({nm, "_stall_resp"}, {63'b0, stall}, 64'd0);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      readEnable  = 1'b0;
      writeEnable = 1'b0;
    end
  endtask

  initial begin
    int          d1;
    int unsigned sz, r;
    logic [63:0] a, dd;
    logic [2:0]  f3;
    bit          re, we;

    reset = 1'b1; readEnable = 1'b0; writeEnable = 1'b0;
    addr = '0; writeData = '0; funct3 = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_readData", readData, 64'd0);
    chk("reset_fault", {63'b0, fault}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;

    for (int unsigned i = 0; i < DEPTH; i++)
      access(0, 1, 64'(8*i), {$urandom, $urandom}, 3'b011, 0, "fill");

    access(0, 1, 64'h10, 64'h1122334455667788, 3'b011, 0, "t1_sd");
    access(1, 0, 64'h10, 64'h0, 3'b011, 0, "t1_ld");
    chk("t1_ld_const", readData, 64'h1122334455667788);

    access(0, 1, 64'h13, 64'hFF, 3'b000, 0, "t2_sb");
    access(1, 0, 64'h13, 64'h0, 3'b000, 0, "t2_lb");
    chk("t2_lb_const", readData, 64'hFFFFFFFFFFFFFFFF);
    access(1, 0, 64'h13, 64'h0, 3'b100, 0, "t2_lbu");
    chk("t2_lbu_const", readData, 64'h00000000000000FF);
    access(1, 0, 64'h10, 64'h0, 3'b011, 0, "t2_ld");
    chk("t2_ld_const", readData, 64'h11223344FF667788);

    access(1, 0, 64'h11, 64'h0, 3'b001, 0, "t3_lh_misal");
    access(0, 1, 64'h16, 64'hDEADBEEF, 3'b010, 0, "t3_sw_misal");
    access(1, 0, 64'h10, 64'h0, 3'b011, 0, "t3_ld");

    access(1, 0, 64'(8*DEPTH), 64'h0, 3'b011, 0, "t4_range");
    access(1, 1, 64'h10, 64'h5555, 3'b011, 0, "t4_both");
    access(1, 0, 64'h10, 64'h0, 3'b111, 0, "t4_f3_111");
    access(0, 1, 64'h10, 64'h77, 3'b100, 0, "t4_store_unsigned");
    access(1, 0, 64'h10, 64'h0, 3'b011, 0, "t4_ld");

    // Store aborted by reset while waiting: no commit, readData cleared.
    readEnable = 1'b0; writeEnable = 1'b1; addr = 64'h20;
    writeData = 64'hAAAA; funct3 = 3'b011;
    @(posedge clk); #1;
    reset = 1'b1; writeEnable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd = '0;
    @(negedge clk);
    chk("t5_stall", {63'b0, stall}, 64'd0);
    chk("t5_readData", readData, 64'd0);
    chk("t5_done", {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    access(1, 0, 64'h20, 64'h0, 3'b011, 0, "t5_ld");

    access(0, 1, 64'h10, 64'h80000000, 3'b010, 0, "t6_sw");
    access(1, 0, 64'h10, 64'h0, 3'b010, 1, "t6_lw");
    chk("t6_lw_const", readData, 64'hFFFFFFFF80000000);
    d1 = last_done_cyc;
    access(1, 0, 64'h10, 64'h0, 3'b110, 0, "t6_lwu");
    chk("t6_lwu_const", readData, 64'h0000000080000000);
    chk("t6_spacing", 64'(last_done_cyc - d1), 64'(LAT + 2));

    for (int unsigned i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      re = (r <= 4);
      we = (r == 0) || (r > 4);
      f3 = 3'($urandom_range(0, 7));
      if (we && !re && $urandom_range(0, 7) != 0) f3[2] = 1'b0;
      sz = 1 << f3[1:0];
      a  = 64'($urandom_range(0, 8*DEPTH + 15));
      if ($urandom_range(0, 4) != 0) a = a & ~64'(sz - 1);
      dd = {$urandom, $urandom};
      access(re, we, a, dd, f3, bit'($urandom_range(0, 1)), "rand");
    end

    readEnable = 1'b0; writeEnable = 1'b0;
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave answering the 64-bit datapath's load/store port (addr, writeData, read/write enables, funct3 size code).
- Provides a doubleword-organised, little-endian RAM with a configurable access latency.
- Supports RISC-V byte/half/word/double sizes with sign/zero extension and misalignment/range fault detection.
- Drives a stall to freeze the core until each access completes.

Parameters:
- N, 64, data/address width (fixed at 64 for lane logic).
- DEPTH, 64, number of 64-bit doublewords; byte address range 0..8*DEPTH-1.
- LATENCY, 2, WAIT-state cycles per access, legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- readEnable  in  1  load request.
- writeEnable  in  1  store request.
- addr  in  N  byte address.
- writeData  in  N  store data, right-aligned.
- funct3  in  3  bits [1:0] size (00 B, 01 H, 10 W, 11 D); bit 2 = unsigned load.
- readData  out  N  extended load result; registered.
- stall  out  1  core must hold PC/state.
- done  out  1  one-cycle access-complete pulse.
- fault  out  1  completed access was illegal; registered, valid with done.

Behaviour:
- Reset values: state IDLE, readData=0, done=0, fault=0, counter=0. RAM contents are not reset. Any pending write is discarded.
- Request req = readEnable | writeEnable. Inputs are sampled only in IDLE.
- stall = (state==IDLE & req) | (state==WAIT). It is combinational and low in RESP.
- Illegal request (fault) if any of:
  - readEnable & writeEnable both set;
  - addr not a multiple of size (H: addr[0]; W: addr[1:0]; D: addr[2:0]);
  - addr[N-1:3] >= DEPTH;
  - funct3 = 111 for a load;
  - funct3[2]=1 for a store.
- IDLE:
  - req legal: latch addr, writeData, funct3, op; counter <= LATENCY-1; go to WAIT.
  - req illegal: fault <= 1; go directly to RESP; RAM and readData untouched.
  - No req: stay in IDLE.
- WAIT:
  - counter != 0: decrement.
  - counter == 0, store: read-modify-write the target doubleword, replacing only the addressed lanes. Bytes at addr[2:0]..addr[2:0]+size-1 take writeData low bytes; other lanes keep old values. Commits at this edge.
  - counter == 0, load: extract the lanes, sign-extend (funct3[2]=0) or zero-extend, register into readData.
  - Then fault <= 0 and go to RESP.
- RESP: done=1, stall=0. Unconditionally go to IDLE next edge, so a request present in the RESP cycle is ignored.
- Latency: request first visible in cycle c gives done in cycle c+LATENCY+1. An illegal request gives done in c+1.
- readData holds the last load value through stores and faults. fault holds until the next completion.
- Back-to-back: minimum one IDLE cycle between accesses.
- Reset in any state: immediate return to IDLE. A store reset before its commit edge leaves RAM unchanged.
- Byte order is little-endian: byte k of a doubleword is bits [8k+7:8k].

Test Plan:
1. LATENCY=2. SD addr=0x10 data=0x1122334455667788 in cycle 0 → stall high cycles 0-2, done in cycle 3, fault=0. Then LD 0x10 → readData=0x1122334455667788 at its done.
2. SB addr=0x13 data=0xFF over the cycle-1 doubleword, then LB 0x13 → 0xFFFFFFFFFFFFFFFF. LBU 0x13 → 0x00000000000000FF. LD 0x10 → 0x11223344FF667788.
3. LH addr=0x11 → done in cycle c+1, fault=1, readData unchanged. SW addr=0x16 → fault=1, RAM doubleword at 0x10 unchanged.
4. LD addr=8*DEPTH → fault=1. readEnable=writeEnable=1 → fault=1, no RAM change. Load with funct3=111 → fault=1.
5. Start SD addr=0x20 data=0xAAAA, assert reset during WAIT before the commit edge → next cycle state IDLE, stall=0, readData=0. Subsequent LD 0x20 returns the prior contents.
6. Back-to-back LW 0x10 (signed, value 0x80000000 preloaded) then LWU 0x10 with req held high throughout → readData 0xFFFFFFFF80000000, then 0x0000000080000000. done pulses spaced LATENCY+2 cycles apart.
